// File: rtl/gpu_noc_pkg.sv
// ---------------------------------------------------------------------------
// gpu_noc_pkg
// Shared NoC definitions used by the group router, the network interface and
// the spine link buffers.
//
// Contents
//   DWIDTH / AWIDTH       default flit and destination-address widths
//   DEST_MSB / DEST_LSB   bit positions of the destination field in a flit
//   flit_t / dest_t       flit and destination typedefs at the default widths
//   flit_dest()           extracts the destination field from a flit
// ---------------------------------------------------------------------------
package gpu_noc_pkg;

    localparam int DWIDTH   = 16;
    localparam int AWIDTH   = 6;

    // The destination address occupies the top AWIDTH bits of every flit.
    localparam int DEST_MSB = DWIDTH - 1;
    localparam int DEST_LSB = DWIDTH - AWIDTH;

    typedef logic [DWIDTH-1:0] flit_t;
    typedef logic [AWIDTH-1:0] dest_t;

    function automatic dest_t flit_dest(input flit_t flit);
        return flit[DEST_MSB:DEST_LSB];
    endfunction

endpackage : gpu_noc_pkg

// File: rtl/noc_sync_fifo.sv
// ---------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock FIFO with a first-word-fall-through read port. The head entry
// is always visible on rd_data, and rd_en retires it at the next clock edge.
//
// The caller must not assert wr_en while the FIFO is full unless rd_en is
// asserted in the same cycle. A simultaneous write and read on a full FIFO is
// safe: the slot being written is the head slot, which is read combinationally
// during this cycle and overwritten only at the clock edge.
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous, active-high reset (pointers and count only)
//   wr_en     in   write wr_data at the tail
//   wr_data   in   DWIDTH-bit entry to store
//   rd_en     in   retire the head entry
//   rd_data   out  head entry (undefined content when empty)
//   count     out  occupied entries, 0..DEPTH
//   full      out  count == DEPTH
//   empty     out  count == 0
// ---------------------------------------------------------------------------
module noc_sync_fifo #(
    parameter int DWIDTH = gpu_noc_pkg::DWIDTH,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DWIDTH-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DWIDTH-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // NOTE: the storage array has no reset; an entry only becomes visible
    // once count says it was written, so clearing it would cost logic for nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule : noc_sync_fifo

// File: rtl/spine_link_buffer.sv
// ---------------------------------------------------------------------------
// spine_link_buffer
// Buffered point-to-point link from one group router's spine output to the
// peer router's spine input. The upstream spine has no backpressure, so
// bursts are absorbed in a FIFO and flits that arrive when it is full are
// dropped and counted. Delivery can be paced with MIN_GAP idle cycles after
// each flit to protect the peer router's input FIFO.
//
// Parameters
//   DWIDTH     flit width
//   AWIDTH     destination field width (top AWIDTH bits of the flit)
//   DEPTH      FIFO entries, power of two, >= 2
//   MIN_GAP    idle cycles forced after each delivered flit (0 = back-to-back)
//   CNT_WIDTH  width of the saturating drop counter
//
// Ports
//   clk              in   link clock
//   reset            in   asynchronous, active-high reset
//   link_en          in   1 = operational, 0 = frozen (no accept, no deliver)
//   clear_stats      in   synchronous clear of drop_count / overflow_sticky
//   in_data/in_valid in   flit from the upstream spine output
//   out_data         out  flit to the downstream spine input (0 when idle)
//   out_valid        out  out_data / out_dest_addr are valid
//   out_dest_addr    out  destination field of the presented flit (0 when idle)
//   out_ready        in   downstream accepts the presented flit
//   fifo_count       out  occupied FIFO entries
//   fifo_full        out  FIFO holds DEPTH entries
//   fifo_empty       out  FIFO holds no entries
//   drop_count       out  flits lost to overflow, saturating at all-ones
//   overflow_sticky  out  set on the first drop, held until clear/reset
// ---------------------------------------------------------------------------
module spine_link_buffer #(
    parameter int DWIDTH    = gpu_noc_pkg::DWIDTH,
    parameter int AWIDTH    = gpu_noc_pkg::AWIDTH,
    parameter int DEPTH     = 8,
    parameter int MIN_GAP   = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   link_en,
    input  logic                   clear_stats,
    input  logic [DWIDTH-1:0]      in_data,
    input  logic                   in_valid,
    output logic [DWIDTH-1:0]      out_data,
    output logic                   out_valid,
    output logic [AWIDTH-1:0]      out_dest_addr,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic                   overflow_sticky
);

    // The gap counter must hold MIN_GAP; keep at least one bit so the
    // back-to-back configuration still has a (constant zero) register.
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_GAP);

    logic              push;
    logic              pop;
    logic              accept;
    logic              drop;
    logic [DWIDTH-1:0] head;
    logic [GW-1:0]     gap_cnt;

    // -----------------------------------------------------------------------
    // Transfer qualification
    // -----------------------------------------------------------------------
    assign push      = in_valid & link_en;
    assign out_valid = ~fifo_empty & link_en & (gap_cnt == '0);
    assign pop       = out_valid & out_ready;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign accept = push & (~fifo_full | pop);
    assign drop   = push & fifo_full & ~pop;

    noc_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // -----------------------------------------------------------------------
    // Output presentation: the link carries zeros whenever nothing is valid,
    // so the peer never sees a stale flit.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        out_data      = '0;
        out_dest_addr = '0;
        if (out_valid) begin
            out_data      = head;
            out_dest_addr = head[DWIDTH-1 -: AWIDTH];
        end
    end

    // -----------------------------------------------------------------------
    // Pacing: reload on every delivered flit, count down otherwise. While the
    // link is frozen the remaining gap is held so pacing resumes where it was.
    // -----------------------------------------------------------------------
    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (pop) begin
            gap_cnt <= GAP_RELOAD;
        end else if (link_en && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Drop statistics. A clear wins over a drop in the same cycle, so that
    // drop is neither counted nor flagged.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end else if (clear_stats) begin
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end else if (drop) begin
            if (drop_count != '1) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
            overflow_sticky <= 1'b1;
        end
    end

endmodule : spine_link_buffer

// File: tb/tb_spine_link_buffer.sv
// ---------------------------------------------------------------------------
// tb_spine_link_buffer
// Two instances share one stimulus stream: dut0 is the back-to-back default
// (MIN_GAP=0, 16-bit drop counter), dut1 is paced (MIN_GAP=2) with a 3-bit
// drop counter so saturation is reachable. A queue-based reference model per
// instance predicts every output each cycle; directed steps add explicit
// expectations for the documented scenarios, followed by a random phase.
// ---------------------------------------------------------------------------
module tb_spine_link_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        link_en;
    logic        clear_stats;
    logic [15:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic [15:0] o_data0,  o_data1;
    logic        o_valid0, o_valid1;
    logic [5:0]  o_dest0,  o_dest1;
    logic [3:0]  cnt0,     cnt1;
    logic        full0,    full1;
    logic        empty0,   empty1;
    logic [15:0] dc0;
    logic [2:0]  dc1;
    logic        sticky0,  sticky1;

    always #5 clk = ~clk;

    spine_link_buffer #(
        .DEPTH(DEPTH), .MIN_GAP(0), .CNT_WIDTH(16)
    ) dut0 (
        .clk(clk), .reset(reset), .link_en(link_en), .clear_stats(clear_stats),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(o_data0), .out_valid(o_valid0), .out_dest_addr(o_dest0),
        .out_ready(out_ready), .fifo_count(cnt0), .fifo_full(full0),
        .fifo_empty(empty0), .drop_count(dc0), .overflow_sticky(sticky0)
    );

    spine_link_buffer #(
        .DEPTH(DEPTH), .MIN_GAP(2), .CNT_WIDTH(3)
    ) dut1 (
        .clk(clk), .reset(reset), .link_en(link_en), .clear_stats(clear_stats),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(o_data1), .out_valid(o_valid1), .out_dest_addr(o_dest1),
        .out_ready(out_ready), .fifo_count(cnt1), .fifo_full(full1),
        .fifo_empty(empty1), .drop_count(dc1), .overflow_sticky(sticky1)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: one flit queue, remaining idle gap, drop tally and
    // sticky flag per instance.
    // ------------------------------------------------------------------
    typedef gpu_noc_pkg::flit_t flit_q_t[$];
    flit_q_t mq [2];
    int      mgap   [2];
    int      mdrops [2];
    logic    msticky[2];

    function automatic int min_gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic int cnt_max_of(input int k);
        return (k == 0) ? 65535 : 7;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mgap[k]    = 0;
            mdrops[k]  = 0;
            msticky[k] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int   sz;
            logic vld, pop, push, full, drop;
            sz   = mq[k].size();
            vld  = (sz != 0) && link_en && (mgap[k] == 0);
            pop  = vld && out_ready;
            push = in_valid && link_en;
            full = (sz == DEPTH);
            drop = 1'b0;
            if (pop) begin
                void'(mq[k].pop_front());
                mgap[k] = min_gap_of(k);
            end else if (link_en && mgap[k] > 0) begin
                mgap[k]--;
            end
            if (push) begin
                if (!full || pop) mq[k].push_back(in_data);
                else              drop = 1'b1;
            end
            if (clear_stats) begin
                mdrops[k]  = 0;
                msticky[k] = 1'b0;
            end else if (drop) begin
                if (mdrops[k] < cnt_max_of(k)) mdrops[k]++;
                msticky[k] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic        exp_vld;
            logic [15:0] exp_data;
            exp_vld  = (mq[k].size() != 0) && link_en && (mgap[k] == 0);
            exp_data = exp_vld ? mq[k][0] : 16'h0000;
            check($sformatf("dut%0d out_valid", k), 32'(k == 0 ? o_valid0 : o_valid1), 32'(exp_vld));
            check($sformatf("dut%0d out_data", k), 32'(k == 0 ? o_data0 : o_data1), 32'(exp_data));
            check($sformatf("dut%0d out_dest_addr", k), 32'(k == 0 ? o_dest0 : o_dest1),
                  32'(exp_data[gpu_noc_pkg::DEST_MSB:gpu_noc_pkg::DEST_LSB]));
            check($sformatf("dut%0d fifo_count", k), 32'(k == 0 ? cnt0 : cnt1), 32'(mq[k].size()));
            check($sformatf("dut%0d fifo_full", k), 32'(k == 0 ? full0 : full1), 32'(mq[k].size() == DEPTH));
            check($sformatf("dut%0d fifo_empty", k), 32'(k == 0 ? empty0 : empty1), 32'(mq[k].size() == 0));
            check($sformatf("dut%0d drop_count", k), (k == 0) ? 32'(dc0) : 32'(dc1), 32'(mdrops[k]));
            check($sformatf("dut%0d overflow_sticky", k), 32'(k == 0 ? sticky0 : sticky1), 32'(msticky[k]));
        end
    endtask

    // Apply inputs just after the falling edge and compare once settled.
    task automatic drive(input logic iv, input logic [15:0] d, input logic en,
                         input logic rdy, input logic clr);
        in_valid    = iv;
        in_data     = d;
        link_en     = en;
        out_ready   = rdy;
        clear_stats = clr;
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_update();
        @(negedge clk);
    endtask

    task automatic cyc(input logic iv, input logic [15:0] d, input logic en,
                       input logic rdy, input logic clr);
        drive(iv, d, en, rdy, clr);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; link_en = 1'b1; out_ready = 1'b1; clear_stats = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        check("reset out_valid", 32'(o_valid0), 32'd0);
        check("reset fifo_empty", 32'(empty0), 32'd1);
        tick();
        reset = 1'b0;
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

        // 1: single flit, one cycle latency, destination field extraction
        cyc(1'b1, 16'hA83C, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        check("t1 out_valid", 32'(o_valid0), 32'd1);
        check("t1 out_data", 32'(o_data0), 32'hA83C);
        check("t1 out_dest_addr", 32'(o_dest0), 32'h2A);
        tick();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        check("t1 fifo_empty after", 32'(empty0), 32'd1);
        tick();
        repeat (4) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

        // 2: overflow with out_ready held low, then in-order release
        for (int i = 1; i <= 10; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("t2 fifo_full", 32'(full0), 32'd1);
        check("t2 drop_count", 32'(dc0), 32'd2);
        check("t2 overflow_sticky", 32'(sticky0), 32'd1);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            check("t2 release order", 32'(o_data0), 32'(i));
            tick();
        end
        repeat (30) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

        // 3: push into a full FIFO while the head leaves
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0BEE, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("t3 count stays full", 32'(cnt0), 32'd8);
        check("t3 drop_count unchanged", 32'(dc0), 32'd2);
        tick();
        repeat (30) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

        // 4: pacing on the MIN_GAP=2 instance
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'h2000 + 16'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            check("t4 paced out_valid", 32'(o_valid1), 32'((i % 3) == 0));
            tick();
        end
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

        // 5: freeze with flits buffered, inputs ignored, then resume
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h3A00 + 16'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'(i % 2), 16'h3F00 + 16'(i), 1'b0, 1'b1, 1'b0);
            check("t5 frozen out_valid", 32'(o_valid0), 32'd0);
            check("t5 frozen count", 32'(cnt0), 32'd3);
            tick();
        end
        drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        check("t5 resume head", 32'(o_data0), 32'h3A00);
        tick();
        repeat (12) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

        // 6: asynchronous reset mid-burst
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 13; i++) cyc(1'b1, 16'h4000 + 16'(i), 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("t6 before reset count", 32'(cnt0), 32'd4);
        check("t6 before reset drops", 32'(dc0), 32'd5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("t6 async out_valid", 32'(o_valid0), 32'd0);
        check("t6 async fifo_empty", 32'(empty0), 32'd1);
        check("t6 async drop_count", 32'(dc0), 32'd0);
        tick();
        reset = 1'b0;

        // clear_stats coincident with a drop: the drop is not counted
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'h5000 + 16'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("t6 clear beats drop count", 32'(dc0), 32'd0);
        check("t6 clear beats drop sticky", 32'(sticky0), 32'd0);
        tick();

        // drop counter saturation on the 3-bit instance
        repeat (10) cyc(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("sat dut1 drop_count", 32'(dc1), 32'd7);
        check("sat dut0 drop_count", 32'(dc0), 32'd10);
        tick();

        // Random phase against the model
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom),
                1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 49) == 0));
        end
        repeat (40) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_spine_link_buffer
